// File: rtl/z_core_pkg.sv
// rtl/z_core_pkg.sv - shared constants and state type for the z_core instruction FIFO
package z_core_pkg;

  localparam int Z_BURST_LEN = 4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } ififo_state_e;

endpackage

// File: rtl/z_core_fifo_ram.sv
// rtl/z_core_fifo_ram.sv - DEPTH x WIDTH array, synchronous write, registered read with write-through
module z_core_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Forwarding lets a beat written this cycle become the head on the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/z_core_instr_fifo.sv
// rtl/z_core_instr_fifo.sv - prefetch-to-decode {pc, instr} FIFO with flush/drain of stale bursts
// Optional same-cycle wr->rd bypass when empty: Z_CORE_IFIFO_BYPASS_EN
module z_core_instr_fifo
  import z_core_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = Z_BURST_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     burst_pend,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_WIDTH-1:0]    wr_instr,
  input  logic [ADDR_WIDTH-1:0]    wr_pc,
  input  logic                     wr_last,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_WIDTH-1:0]    rd_instr,
  output logic [ADDR_WIDTH-1:0]    rd_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     burst_room
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [PW-1:0] ROOM_LIMIT = PW'(DEPTH - BURST_LEN);

  ififo_state_e state;
  logic         mid_burst;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic          rd_valid_q;
  logic          full, empty;
  logic          wr_fire, push, pop, byp_take;
  logic [EW-1:0] head;
  logic [DATA_WIDTH-1:0] head_instr;
  logic [ADDR_WIDTH-1:0] head_pc;

  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  assign wr_ready   = (state == ST_DRAIN) || !full;
  assign burst_room = (state == ST_RUN) && (count <= ROOM_LIMIT);
  assign wr_fire    = wr_valid && wr_ready;

  assign head_pc    = head[EW-1:DATA_WIDTH];
  assign head_instr = head[DATA_WIDTH-1:0];

`ifdef Z_CORE_IFIFO_BYPASS_EN
  logic byp_hit;
  assign byp_hit  = empty && (state == ST_RUN);
  assign byp_take = byp_hit && wr_valid && rd_ready;
  assign rd_valid = byp_hit ? wr_valid : rd_valid_q;
  assign rd_instr = byp_hit ? wr_instr : head_instr;
  assign rd_pc    = byp_hit ? wr_pc    : head_pc;
`else
  assign byp_take = 1'b0;
  assign rd_valid = rd_valid_q;
  assign rd_instr = head_instr;
  assign rd_pc    = head_pc;
`endif

  // Beats consumed straight through the bypass never touch the array.
  assign push = wr_fire && (state == ST_RUN) && !flush && !byp_take;
  assign pop  = rd_valid_q && rd_ready && !flush;

  always_comb begin
    wr_ptr_nxt = wr_ptr + PW'(push);
    rd_ptr_nxt = rd_ptr + PW'(pop);
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      rd_valid_q <= (wr_ptr_nxt != rd_ptr_nxt);
    end
  end

  // A flush only needs DRAIN when some beats of a burst are still on their way.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      mid_burst <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (flush) begin
            mid_burst <= 1'b0;
            if (wr_fire ? !wr_last : (burst_pend || mid_burst)) begin
              state <= ST_DRAIN;
            end
          end else if (wr_fire) begin
            mid_burst <= !wr_last;
          end
        end
        ST_DRAIN: begin
          mid_burst <= 1'b0;
          if (wr_fire && wr_last && !(flush && burst_pend)) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state     <= ST_RUN;
          mid_burst <= 1'b0;
        end
      endcase
    end
  end

  z_core_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({wr_pc, wr_instr}),
    .raddr (rd_ptr_nxt[AW-1:0]),
    .rdata (head)
  );

endmodule

// File: tb/tb_z_core_instr_fifo.sv
// tb/tb_z_core_instr_fifo.sv - directed self-checking bench for z_core_instr_fifo
module tb_z_core_instr_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        burst_pend = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_instr = '0;
  logic [31:0] wr_pc = '0;
  logic        wr_last = 1'b0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_instr;
  logic [31:0] rd_pc;
  logic [4:0]  count;
  logic        burst_room;

  int checks = 0;
  int errors = 0;

  z_core_instr_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .burst_pend (burst_pend),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_instr   (wr_instr),
    .wr_pc      (wr_pc),
    .wr_last    (wr_last),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_instr   (rd_instr),
    .rd_pc      (rd_pc),
    .count      (count),
    .burst_room (burst_room)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic last);
    wr_valid = 1'b1;
    wr_pc    = pc;
    wr_instr = pc ^ 32'hA5A5_0000;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  initial begin
    // 1: reset
    tick();
    tick();
    chk("reset rd_valid", 64'(rd_valid), 64'd0);
    chk("reset count", 64'(count), 64'd0);
    chk("reset burst_room", 64'(burst_room), 64'd1);
    chk("reset wr_ready", 64'(wr_ready), 64'd1);
    chk("reset rd_pc", 64'(rd_pc), 64'd0);
    chk("reset rd_instr", 64'(rd_instr), 64'd0);
    rst = 1'b0;

    // 2: one burst, then drain in order
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), i == 3);
    chk("burst count", 64'(count), 64'd4);
    chk("burst room", 64'(burst_room), 64'd1);
    chk("burst rd_valid", 64'(rd_valid), 64'd1);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("burst rd_pc", 64'(rd_pc), 64'(32'h100 + 32'(4 * i)));
      chk("burst rd_instr", 64'(rd_instr), 64'((32'h100 + 32'(4 * i)) ^ 32'hA5A5_0000));
      tick();
    end
    rd_ready = 1'b0;
    chk("burst drained count", 64'(count), 64'd0);
    chk("burst drained rd_valid", 64'(rd_valid), 64'd0);

    // 3: fill to full across the pointer wrap
    for (int i = 0; i < 16; i++) begin
      push(32'h300 + 32'(4 * i), (i % 4) == 3);
      if (i == 11) chk("room at 12", 64'(burst_room), 64'd1);
      if (i == 12) chk("room at 13", 64'(burst_room), 64'd0);
    end
    chk("full count", 64'(count), 64'd16);
    chk("full wr_ready", 64'(wr_ready), 64'd0);
    chk("full burst_room", 64'(burst_room), 64'd0);
    wr_valid = 1'b1; wr_pc = 32'h340; wr_instr = 32'h340 ^ 32'hA5A5_0000; wr_last = 1'b1;
    tick();
    chk("17th held count", 64'(count), 64'd16);
    chk("17th held wr_ready", 64'(wr_ready), 64'd0);
    chk("full head", 64'(rd_pc), 64'h300);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("after pop count", 64'(count), 64'd15);
    chk("after pop wr_ready", 64'(wr_ready), 64'd1);
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
    chk("17th stored count", 64'(count), 64'd16);
    rd_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("wrap order rd_pc", 64'(rd_pc), 64'(32'h300 + 32'(4 * i)));
      tick();
    end
    rd_ready = 1'b0;
    chk("wrap drained count", 64'(count), 64'd0);

    // 4: flush after beat 2 of 4
    push(32'h400, 1'b0);
    push(32'h404, 1'b0);
    chk("pre-flush count", 64'(count), 64'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush count", 64'(count), 64'd0);
    chk("flush rd_valid", 64'(rd_valid), 64'd0);
    chk("drain burst_room", 64'(burst_room), 64'd0);
    chk("drain wr_ready", 64'(wr_ready), 64'd1);
    push(32'h408, 1'b0);
    chk("drop beat3 count", 64'(count), 64'd0);
    chk("drop beat3 rd_valid", 64'(rd_valid), 64'd0);
    push(32'h40C, 1'b1);
    chk("drop beat4 count", 64'(count), 64'd0);
    chk("back to run room", 64'(burst_room), 64'd1);
    push(32'h200, 1'b1);
    chk("post-drain count", 64'(count), 64'd1);
    chk("post-drain rd_pc", 64'(rd_pc), 64'h200);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;

    // 5a: flush coinciding with wr_last
    push(32'h500, 1'b0);
    flush = 1'b1;
    push(32'h504, 1'b1);
    flush = 1'b0;
    chk("flush+last count", 64'(count), 64'd0);
    chk("flush+last no drain", 64'(burst_room), 64'd1);
    push(32'h600, 1'b1);
    chk("flush+last next pc", 64'(rd_pc), 64'h600);
    chk("flush+last next count", 64'(count), 64'd1);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;

    // 5b: flush with burst_pend before the first beat
    burst_pend = 1'b1; flush = 1'b1;
    tick();
    burst_pend = 1'b0; flush = 1'b0;
    chk("pend flush drain", 64'(burst_room), 64'd0);
    for (int i = 0; i < 4; i++) push(32'h700 + 32'(4 * i), i == 3);
    chk("pend dropped count", 64'(count), 64'd0);
    chk("pend back to run", 64'(burst_room), 64'd1);
    push(32'h800, 1'b1);
    chk("pend next pc", 64'(rd_pc), 64'h800);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;

    // reset mid-burst clears mid_burst, so a later flush does not drain
    push(32'hB00, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst mid-burst count", 64'(count), 64'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("rst mid-burst no drain", 64'(burst_room), 64'd1);

    // 6: concurrent push/pop at count 8
    for (int i = 0; i < 8; i++) push(32'h900 + 32'(4 * i), 1'b1);
    chk("pre-concurrent count", 64'(count), 64'd8);
    rd_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wr_valid = 1'b1; wr_pc = 32'h920 + 32'(4 * k); wr_instr = 32'h0; wr_last = 1'b1;
      tick();
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    chk("concurrent count", 64'(count), 64'd8);
    chk("concurrent head", 64'(rd_pc), 64'h950);
    for (int i = 0; i < 8; i++) tick();
    rd_ready = 1'b0;
    chk("concurrent drained", 64'(count), 64'd0);

`ifdef Z_CORE_IFIFO_BYPASS_EN
    wr_valid = 1'b1; wr_pc = 32'hA00; wr_instr = 32'h1234; wr_last = 1'b1; rd_ready = 1'b1;
    #1;
    chk("bypass rd_valid", 64'(rd_valid), 64'd1);
    chk("bypass rd_pc", 64'(rd_pc), 64'hA00);
    tick();
    wr_valid = 1'b0; wr_last = 1'b0; rd_ready = 1'b0;
    chk("bypass count", 64'(count), 64'd0);
`else
    wr_valid = 1'b1; wr_pc = 32'hA00; wr_instr = 32'h1234; wr_last = 1'b1; rd_ready = 1'b0;
    #1;
    chk("latency same-cycle rd_valid", 64'(rd_valid), 64'd0);
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
    chk("latency next rd_valid", 64'(rd_valid), 64'd1);
    chk("latency next rd_pc", 64'(rd_pc), 64'hA00);
    chk("latency count", 64'(count), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
